// File: rtl/fetch_load_sequencer.sv
// Load sequencer for the AXIS fetch unit: steps through A, B and instruction loads, checks beat
// counts and TLAST, then pulses pe_start. Optional watchdog: define LOAD_TIMEOUT_EN.
module fetch_load_sequencer #(
  parameter int BRAM_DEPTH       = 10,
  parameter int INSTR_BRAM_DEPTH = 11,
  parameter int PAD_HOLD         = 4,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                      S_AXIS_ACLK,
  input  logic                      S_AXIS_ARESET,
  input  logic                      start,
  input  logic [31:0]               cfg_row_width,
  input  logic [BRAM_DEPTH:0]       cfg_a_words,
  input  logic [BRAM_DEPTH:0]       cfg_b_words,
  input  logic [INSTR_BRAM_DEPTH:0] cfg_i_words,
  input  logic                      mon_tvalid,
  input  logic                      mon_tready,
  input  logic                      mon_tlast,
  input  logic                      valid_fu2pe,
  output logic [1:0]                bram_sel,
  output logic [31:0]               row_width,
  output logic                      pe_start,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                err_code
);

  localparam int CW = ((INSTR_BRAM_DEPTH > BRAM_DEPTH) ? INSTR_BRAM_DEPTH : BRAM_DEPTH) + 1;
  localparam int HW = $clog2(PAD_HOLD + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_A, S_DRAIN_A, S_LOAD_B, S_DRAIN_B,
    S_LOAD_I, S_WAIT_PE, S_PE_GO, S_DONE, S_ERR
  } state_t;

  state_t                    state, state_n;
  logic [1:0]                err_code_n;
  logic [BRAM_DEPTH:0]       a_w, b_w;
  logic [INSTR_BRAM_DEPTH:0] i_w;
  logic [CW-1:0]             beat_cnt, cur_words;
  logic [HW-1:0]             hold_cnt;
  logic                      beat, in_load, in_drain, accept, last_beat;

  assign beat      = mon_tvalid & mon_tready;
  assign in_load   = (state == S_LOAD_A) | (state == S_LOAD_B) | (state == S_LOAD_I);
  assign in_drain  = (state == S_DRAIN_A) | (state == S_DRAIN_B);
  assign accept    = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
  assign last_beat = (beat_cnt == cur_words - CW'(1));

`ifdef LOAD_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
  logic          wd_state;
  assign wd_state = in_load | (state == S_WAIT_PE);
`endif

  always_comb begin
    cur_words = CW'(i_w);
    case (state)
      S_LOAD_A: cur_words = CW'(a_w);
      S_LOAD_B: cur_words = CW'(b_w);
      default:  cur_words = CW'(i_w);
    endcase
  end

  always_comb begin
    state_n    = state;
    err_code_n = err_code;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          err_code_n = 2'b00;
          if (cfg_i_words == '0) begin
            state_n    = S_ERR;
            err_code_n = 2'b11;
          end else if (cfg_a_words != '0) state_n = S_LOAD_A;
          else if (cfg_b_words != '0)     state_n = S_LOAD_B;
          else                            state_n = S_LOAD_I;
        end
      end
      S_LOAD_A, S_LOAD_B, S_LOAD_I: begin
        if (beat) begin
          if (last_beat) begin
            if (!mon_tlast) begin
              state_n    = S_ERR;
              err_code_n = 2'b10;
            end else if (state == S_LOAD_A) state_n = S_DRAIN_A;
            else if (state == S_LOAD_B)     state_n = S_DRAIN_B;
            else                            state_n = S_WAIT_PE;
          end else if (mon_tlast) begin
            state_n    = S_ERR;
            err_code_n = 2'b01;
          end
        end
      end
      S_DRAIN_A: if (hold_cnt == HW'(PAD_HOLD - 1)) state_n = (b_w != '0) ? S_LOAD_B : S_LOAD_I;
      S_DRAIN_B: if (hold_cnt == HW'(PAD_HOLD - 1)) state_n = S_LOAD_I;
      S_WAIT_PE: if (valid_fu2pe) state_n = S_PE_GO;
      S_PE_GO:   state_n = S_DONE;
      default:   state_n = S_IDLE;
    endcase
`ifdef LOAD_TIMEOUT_EN
    // Only a stall that would otherwise stay put can time out.
    if (wd_state && !beat && state_n == state && wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
      state_n    = S_ERR;
      err_code_n = 2'b11;
    end
`endif
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state     <= S_IDLE;
      err_code  <= 2'b00;
      row_width <= '0;
      a_w       <= '0;
      b_w       <= '0;
      i_w       <= '0;
      beat_cnt  <= '0;
      hold_cnt  <= '0;
    end else begin
      state    <= state_n;
      err_code <= err_code_n;
      if (accept) begin
        row_width <= cfg_row_width;
        a_w       <= cfg_a_words;
        b_w       <= cfg_b_words;
        i_w       <= cfg_i_words;
      end
      if (state_n != state)     beat_cnt <= '0;
      else if (in_load && beat) beat_cnt <= beat_cnt + CW'(1);
      if (state_n != state)     hold_cnt <= '0;
      else if (in_drain)        hold_cnt <= hold_cnt + HW'(1);
    end
  end

`ifdef LOAD_TIMEOUT_EN
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET)                        wd_cnt <= '0;
    else if (beat || state_n != state || !wd_state) wd_cnt <= '0;
    else                                      wd_cnt <= wd_cnt + WW'(1);
  end
`endif

  always_comb begin
    bram_sel = 2'b11;
    pe_start = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      S_LOAD_A, S_DRAIN_A: bram_sel = 2'b00;
      S_LOAD_B, S_DRAIN_B: bram_sel = 2'b01;
      S_LOAD_I, S_WAIT_PE: bram_sel = 2'b10;
      S_PE_GO:             pe_start = 1'b1;
      S_DONE:  begin busy = 1'b0; done = 1'b1; end
      S_ERR:   begin busy = 1'b0; err  = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fetch_load_sequencer.sv
// Directed bench for fetch_load_sequencer: phase-list reference model compared every cycle,
// plus hand-computed literal checks per scenario.
module tb_fetch_load_sequencer;
  localparam int BD = 4, ID = 5, PH = 4, TO = 16;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0]   cfg_rw = '0;
  logic [BD:0]   cfg_a = '0, cfg_b = '0;
  logic [ID:0]   cfg_i = '0;
  logic          tv = 1'b0, tr = 1'b0, tl = 1'b0, vfp = 1'b0;
  logic [1:0]    bram_sel, err_code;
  logic [31:0]   row_width;
  logic          pe_start, busy, done, err;

  fetch_load_sequencer #(.BRAM_DEPTH(BD), .INSTR_BRAM_DEPTH(ID), .PAD_HOLD(PH), .TIMEOUT_CYCLES(TO)) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .start(start), .cfg_row_width(cfg_rw),
    .cfg_a_words(cfg_a), .cfg_b_words(cfg_b), .cfg_i_words(cfg_i),
    .mon_tvalid(tv), .mon_tready(tr), .mon_tlast(tl), .valid_fu2pe(vfp),
    .bram_sel(bram_sel), .row_width(row_width), .pe_start(pe_start), .busy(busy),
    .done(done), .err(err), .err_code(err_code));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  bit cmp_en = 1'b0;

  // Model phases: 0 idle, 1 loading, 2 draining, 3 waiting PE, 4 go, 5 done, 6 error.
  int          m_ph = 0, m_cur = 0, m_seen = 0, m_hold = 0, m_wd = 0, m_code = 0;
  int          m_words[3];
  int          m_q[$];
  logic [31:0] m_rw = '0;

  always @(posedge clk) begin : model
    bit beat;
    int prev, pcur;
    beat = tv && tr;
    prev = m_ph;
    pcur = m_cur;
    if (rst) begin
      m_ph = 0; m_cur = 0; m_seen = 0; m_hold = 0; m_wd = 0; m_code = 0; m_rw = '0;
    end else begin
      case (m_ph)
        0, 5, 6: if (start) begin
          m_rw = cfg_rw;
          m_code = 0;
          m_words[0] = int'(cfg_a); m_words[1] = int'(cfg_b); m_words[2] = int'(cfg_i);
          if (cfg_i == 0) begin
            m_ph = 6; m_code = 3;
          end else begin
            m_q.delete();
            for (int k = 0; k < 3; k++) if (m_words[k] != 0) m_q.push_back(k);
            m_cur = m_q.pop_front(); m_ph = 1; m_seen = 0;
          end
        end
        1: if (beat) begin
          m_seen++;
          if (m_seen == m_words[m_cur]) begin
            if (!tl) begin m_ph = 6; m_code = 2; end
            else if (m_cur == 2) m_ph = 3;
            else begin m_ph = 2; m_hold = 0; end
          end else if (tl) begin
            m_ph = 6; m_code = 1;
          end
        end
        2: begin
          m_hold++;
          if (m_hold == PH) begin m_cur = m_q.pop_front(); m_ph = 1; m_seen = 0; end
        end
        3: if (vfp) m_ph = 4;
        4: m_ph = 5;
        default: m_ph = 0;
      endcase
`ifdef LOAD_TIMEOUT_EN
      if ((prev == 1 || prev == 3) && m_ph == prev && m_cur == pcur && !beat) begin
        m_wd++;
        if (m_wd == TO) begin m_ph = 6; m_code = 3; m_wd = 0; end
      end else m_wd = 0;
`endif
    end
  end

  // Compare and observation process.
  int         pe_total = 0, sel01_total = 0;
  logic [1:0] last_sel = 2'b11;
  logic [1:0] hist[$];

  always @(negedge clk) begin : compare
    logic [38:0] expv, gotv;
    logic [1:0]  esel;
    if (cmp_en) begin
      esel = (m_ph == 1 || m_ph == 2) ? 2'(m_cur) : (m_ph == 3) ? 2'b10 : 2'b11;
      expv = {esel, m_rw, m_ph == 4, m_ph >= 1 && m_ph <= 4, m_ph == 5, m_ph == 6, 2'(m_code)};
      gotv = {bram_sel, row_width, pe_start, busy, done, err, err_code};
      checks++;
      if (gotv !== expv) begin
        errors++;
        $display("FAIL cycle t=%0t got=%h exp=%h", $time, gotv, expv);
      end
      if (pe_start === 1'b1) pe_total++;
      if (bram_sel === 2'b00 || bram_sel === 2'b01) sel01_total++;
      if (bram_sel !== last_sel) begin hist.push_back(bram_sel); last_sel = bram_sel; end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic idle(input int n); tv = 0; tr = 0; tl = 0; repeat (n) tick(); endtask
  task automatic go(input int a, input int b, input int i, input int rw);
    cfg_a = BD'(a); cfg_b = BD'(b); cfg_i = ID'(i); cfg_rw = 32'(rw);
    cfg_a = (BD+1)'(a); cfg_b = (BD+1)'(b); cfg_i = (ID+1)'(i);
    start = 1; tick(); start = 0;
  endtask
  task automatic stream(input int n, input int tl_at);
    for (int k = 1; k <= n; k++) begin tv = 1; tr = 1; tl = (k == tl_at); tick(); end
    tv = 0; tr = 0; tl = 0;
  endtask
  task automatic pulse_v(); vfp = 1; tick(); vfp = 0; endtask

  initial begin
    int pe0, s0, h0;
    logic [7:0] seq;
    tick(); cmp_en = 1; tick();
    chk("rst_sel", bram_sel, 2'b11);
    chk("rst_flags", {pe_start, busy, done, err, err_code}, 6'b0);
    rst = 0; tick();

    // Full A/B/I load; a stray start during the A drain must be ignored.
    pe0 = pe_total; h0 = hist.size();
    go(4, 4, 3, 4);
    chk("t1_sel_a", bram_sel, 2'b00);
    chk("t1_busy", busy, 1'b1);
    stream(4, 4);
    cfg_i = '0; start = 1; tick(); start = 0;
    chk("t1_drain_sel", bram_sel, 2'b00);
    idle(PH - 1);
    chk("t1_sel_b", bram_sel, 2'b01);
    stream(4, 4); idle(PH);
    stream(3, 3); idle(2);
    chk("t1_wait_sel", bram_sel, 2'b10);
    pulse_v(); tick();
    chk("t1_done", done, 1'b1);
    chk("t1_rw", row_width, 32'd4);
    chk("t1_pe_once", pe_total - pe0, 1);
    chk("t1_steps", hist.size() - h0, 4);
    if (hist.size() - h0 >= 4) begin
      seq = {hist[h0], hist[h0+1], hist[h0+2], hist[h0+3]};
      chk("t1_sel_order", seq, 8'b00_01_10_11);
    end

    // Instruction-only load.
    pe0 = pe_total; s0 = sel01_total;
    go(0, 0, 5, 7);
    chk("t2_sel_i", bram_sel, 2'b10);
    stream(5, 5); idle(1); pulse_v(); tick();
    chk("t2_done", done, 1'b1);
    chk("t2_pe_once", pe_total - pe0, 1);
    chk("t2_no_ab", sel01_total - s0, 0);

    // Early TLAST, then a clean reload with an instruction count of 1.
    go(4, 0, 1, 4);
    stream(2, 2);
    chk("t3_err", {err, err_code, bram_sel}, 5'b1_01_11);
    stream(2, 1);
    chk("t3_err_sticky", err_code, 2'b01);
    go(2, 0, 1, 9);
    chk("t3_err_clr", {err, err_code}, 3'b0);
    stream(2, 2); idle(PH); stream(1, 1); pulse_v(); tick();
    chk("t3_done", done, 1'b1);

    // Overrun on B with non-beat stalls (TLAST high while tready low).
    go(0, 3, 2, 1);
    stream(2, 0);
    tv = 1; tr = 0; tl = 1; repeat (5) tick();
    chk("t4_stall_busy", {busy, bram_sel}, 3'b1_01);
    stream(1, 0);
    chk("t4_code", {err, err_code}, 3'b1_10);

    // Reset during LOAD_B.
    pe0 = pe_total;
    go(1, 4, 2, 3);
    stream(1, 1); idle(PH); stream(2, 0);
    rst = 1; tick(); rst = 0;
    chk("t5_rst_out", {bram_sel, row_width, busy, done, err, err_code}, {2'b11, 32'd0, 5'b0});
    stream(2, 2); pulse_v(); tick();
    chk("t5_no_pe", pe_total - pe0, 0);
    chk("t5_idle", {busy, done}, 2'b00);

    // Zero instruction count.
    go(1, 1, 0, 3);
    chk("t6_badcfg", {err, err_code}, 3'b1_11);

    // Long stall in WAIT_PE.
    go(0, 0, 1, 2);
    stream(1, 1); idle(40);
`ifdef LOAD_TIMEOUT_EN
    chk("t7_timeout", {err, err_code}, 3'b1_11);
`else
    chk("t7_still_wait", {busy, bram_sel}, 3'b1_10);
`endif
    pulse_v(); tick();
`ifdef LOAD_TIMEOUT_EN
    chk("t7_after", err, 1'b1);
`else
    chk("t7_after", done, 1'b1);
`endif

    // Full-BRAM A count, then beats while DONE.
    go(16, 0, 1, 5);
    stream(16, 16); idle(PH); stream(1, 1); pulse_v(); tick();
    chk("t8_full_done", done, 1'b1);
    stream(3, 3);
    chk("t8_done_hold", {done, err}, 2'b10);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
